// File: rtl/glyph_pixel_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | glyph_pixel_reader: character-ROM row fetch and 4-bit pixel          |
// | serializer with a one-entry row buffer.  Rev 1.0                     |
// +----------------------------------------------------------------------+
module glyph_pixel_reader #(
  parameter logic [3:0] BLANK_PIXEL = 4'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_char_i,
  input  logic [3:0]  req_row_i,
  input  logic        req_invert_i,
  input  logic        flush_i,
  output logic [11:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [3:0]  pixel_o,
  output logic        pixel_valid_o,
  input  logic        pixel_ready_i
);

  logic        r_inflight;
  logic        r_inflight_inv;
  logic        r_buf_valid;
  logic [31:0] r_buf_data;
  logic        r_shift_valid;
  logic [31:0] r_shift_data;
  logic [2:0]  r_shift_cnt;

  logic        w_accept;
  logic        w_xfer;
  logic        w_last;
  logic        w_take_rom;
  logic [31:0] w_rom_word;

  assign rom_addr_o  = {req_char_i, req_row_i};
  assign req_ready_o = !reset_i && !r_inflight && !r_buf_valid && !flush_i;
  assign w_accept    = req_valid_i && req_ready_o;

  assign w_xfer      = r_shift_valid && pixel_ready_i;
  assign w_last      = w_xfer && (r_shift_cnt == 3'd7);
  assign w_rom_word  = rom_data_i ^ {32{r_inflight_inv}};
  // ROM word goes straight to the shifter when it is free by the end of this edge.
  assign w_take_rom  = r_inflight && (!r_shift_valid || w_last);

  assign pixel_valid_o = r_shift_valid;
  assign pixel_o       = r_shift_valid ? r_shift_data[3:0] : BLANK_PIXEL;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_inflight     <= 1'b0;
      r_inflight_inv <= 1'b0;
    end else if (flush_i) begin
      r_inflight     <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_inflight_inv <= req_invert_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= 32'h0;
    end else if (flush_i) begin
      r_buf_valid <= 1'b0;
    end else if (r_inflight && !w_take_rom) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= w_rom_word;
    end else if (w_last && r_buf_valid) begin
      r_buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_shift_valid <= 1'b0;
      r_shift_data  <= 32'h0;
      r_shift_cnt   <= 3'd0;
    end else if (flush_i) begin
      r_shift_valid <= 1'b0;
      r_shift_cnt   <= 3'd0;
    end else if (w_take_rom) begin
      r_shift_valid <= 1'b1;
      r_shift_data  <= w_rom_word;
      r_shift_cnt   <= 3'd0;
    end else if (w_last) begin
      // Buffered row takes over on the last-pixel edge so the stream has no bubble.
      r_shift_valid <= r_buf_valid;
      r_shift_data  <= r_buf_data;
      r_shift_cnt   <= 3'd0;
    end else if (w_xfer) begin
      r_shift_data  <= {4'h0, r_shift_data[31:4]};
      r_shift_cnt   <= r_shift_cnt + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/glyph_pixel_reader.md
# glyph_pixel_reader

Consumer side of the character ROM. Accepts glyph-row fetch requests (character code + scanline row), drives the ROM address, captures the 32-bit row word one cycle later, and serializes it as eight 4-bit pixels with valid/ready flow control. Sits between the text-mode scan logic and the pixel output pipeline. A one-entry buffer lets back-to-back requests stream without pixel bubbles.

## Interface

- BLANK_PIXEL, default 4'h0: value driven on pixel_o whenever pixel_valid_o is low.

- clk_i  input  1  sole clock; all state updates on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  1  fetch request present.
- req_ready_o  output  1  block can accept a request this cycle.
- req_char_i  input  8  character code.
- req_row_i  input  4  glyph scanline, 0..15.
- req_invert_i  input  1  invert all 8 pixels of this row.
- flush_i  input  1  synchronous discard of all queued and in-flight work.
- rom_addr_o  output  12  ROM address, {req_char_i, req_row_i}, driven combinationally.
- rom_data_i  input  32  ROM row word, valid the cycle after the address is sampled.
- pixel_o  output  4  current pixel.
- pixel_valid_o  output  1  pixel_o is valid.
- pixel_ready_i  input  1  downstream consumes pixel_o this cycle.

## Operation

- ROM word format: pixel k is bits [4k+3:4k], k = 0..7. Pixel 0 is emitted first.
- Accept occurs on an edge where req_valid_i && req_ready_o. The ROM samples rom_addr_o on that same edge.
- req_ready_o = !reset_i && !inflight_q && !buf_valid_q && !flush_i.
- inflight_q is set on accept and cleared on the next edge.
- On the edge where inflight_q = 1, rom_data_i is captured with the request's invert flag applied (word XOR 32'hFFFF_FFFF when inverted):
  - into the shifter if the shifter is empty, or if it is emitting its last pixel with pixel_ready_i = 1;
  - otherwise into buf.
- rom_data_i is ignored on every other edge.
- inflight_q and buf_valid_q are never both 1.
- Shifter: 32-bit data register plus a 3-bit count.
  - On a pixel transfer (pixel_valid_o && pixel_ready_i), data shifts right by 4 and count increments.
  - On the transfer with count = 7, the shifter empties. If buf_valid_q is set, buf loads into the shifter on that same edge and buf_valid_q clears.
  - A loaded shifter resets count to 0.
- pixel_valid_o = shifter occupied. pixel_o = shifter[3:0] when valid, else BLANK_PIXEL.
- While pixel_ready_i = 0, pixel_o and pixel_valid_o hold.
- flush_i = 1 at an edge clears the shifter, buf_valid_q and inflight_q. Any ROM data due that edge is discarded. flush_i takes priority over all loads and shifts.
- Reset, asynchronous, effective immediately:
  - inflight_q = 0, buf_valid_q = 0, shifter empty with count 0.
  - pixel_valid_o = 0, pixel_o = BLANK_PIXEL, req_ready_o = 0.
  - rom_addr_o follows its inputs.
  - Reset asserted mid-glyph drops all work. After deassertion the block is idle with req_ready_o = 1.

## Timing

- Request-to-first-pixel latency: accept at edge E0, ROM data captured at E1, pixel 0 valid after E1 (1 cycle) if the shifter is free.
- Throughput: one glyph row per 8 cycles with pixel_ready_i held high. A new request is accepted at most every other cycle. With continuous requests, pixels stream gap-free.
- Buffer handoff: buf loads the shifter on the same edge as the last-pixel transfer, so no bubble.
- ROM is assumed 1-cycle registered read. rom_data_i must be stable only in the cycle following the sampling edge.

## Test plan

- Single fetch, char 8'h41, row 4'h3, ROM word 32'h7654_3210, pixel_ready_i = 1: rom_addr_o = 12'h413 at accept. Pixels 0,1,…,7 on consecutive cycles starting the cycle after E1. pixel_valid_o drops after the 8th pixel.
- Invert on the same word: pixels F,E,D,C,B,A,9,8.
- Back-to-back requests (words 32'h7654_3210 then 32'hFEDC_BA98) with req_valid_i held and pixel_ready_i = 1: second request accepted one edge after the first capture. 16 consecutive valid pixels 0..F, no gap. req_ready_o low while buf is full.
- Backpressure: pixel_ready_i = 0 for 5 cycles after pixel 2. pixel_o holds 2 and valid holds 1. Pixel 3 follows when ready returns. Nothing is lost or duplicated.
- Flush with shifter at pixel 4, buf full and flush_i pulsed: next cycle pixel_valid_o = 0, pixel_o = BLANK_PIXEL, req_ready_o = 1. A flush during inflight discards that word.
- Async reset mid-glyph: outputs go to reset values without a clock edge. After release, a fresh fetch behaves as in the single-fetch case.
